// File: rtl/adpcm_sample_player.sv
// ADPCM sample sequencer for the jt5205 decoder: fetches sample bytes from sound ROM with
// one byte of prefetch and feeds the decoder one nibble (high first) per sample strobe.
module adpcm_sample_player #(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_cen,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [3:0]    adpcm_din,
  output logic          adpcm_rst,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  typedef enum logic [1:0] {StIdle, StPrefetch, StPlay, StDrain} state_e;

  state_e        state_q;
  logic [7:0]    cur_byte_q, next_byte_q;
  logic          half_q, next_valid_q, more_q;
  logic [AW-1:0] fetch_addr_q, cur_addr_q, end_addr_q;

  logic       fetch_ok, fetch_issue, have_next;
  logic [7:0] avail_byte;

  assign fetch_ok    = rom_cs & rom_ok;
  // A request needs a free buffer and a cycle with rom_cs low after the previous one.
  assign fetch_issue = ((state_q == StPrefetch) || (state_q == StPlay)) && !rom_cs && more_q &&
                       !next_valid_q;
  // A byte arriving in the same cycle as the strobe is usable straight away.
  assign have_next   = next_valid_q | fetch_ok;
  assign avail_byte  = next_valid_q ? next_byte_q : rom_data;
  assign busy        = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rom_cs       <= 1'b0;
      rom_addr     <= '0;
      adpcm_din    <= 4'd0;
      adpcm_rst    <= 1'b1;
      done         <= 1'b0;
      underrun     <= 1'b0;
      cur_byte_q   <= 8'd0;
      next_byte_q  <= 8'd0;
      half_q       <= 1'b0;
      next_valid_q <= 1'b0;
      more_q       <= 1'b0;
      fetch_addr_q <= '0;
      cur_addr_q   <= '0;
      end_addr_q   <= '0;
    end else begin
      done     <= 1'b0;
      underrun <= 1'b0;
      if (start || (stop && (state_q != StIdle))) begin
        state_q      <= StIdle;
        rom_cs       <= 1'b0;
        adpcm_din    <= 4'd0;
        adpcm_rst    <= 1'b1;
        cur_byte_q   <= 8'd0;
        next_byte_q  <= 8'd0;
        half_q       <= 1'b0;
        next_valid_q <= 1'b0;
        more_q       <= 1'b0;
        if (start) begin
          if (start_addr <= end_addr) begin
            state_q      <= StPrefetch;
            more_q       <= 1'b1;
            fetch_addr_q <= start_addr;
            end_addr_q   <= end_addr;
          end else begin
            done <= 1'b1;
          end
        end
      end else begin
        if (fetch_issue) begin
          rom_cs   <= 1'b1;
          rom_addr <= fetch_addr_q;
        end
        if (fetch_ok) begin
          rom_cs       <= 1'b0;
          fetch_addr_q <= rom_addr + AW'(1);
          more_q       <= (rom_addr < end_addr_q);
        end
        case (state_q)
          StPrefetch: begin
            if (fetch_ok) begin
              state_q    <= StPlay;
              cur_byte_q <= rom_data;
              cur_addr_q <= rom_addr;
              half_q     <= 1'b0;
              adpcm_din  <= rom_data[7:4];
              adpcm_rst  <= 1'b0;
            end
          end
          StPlay: begin
            if (fetch_ok) begin
              next_byte_q  <= rom_data;
              next_valid_q <= 1'b1;
            end
            if (sample_cen) begin
              if (!half_q) begin
                adpcm_din <= cur_byte_q[3:0];
                half_q    <= 1'b1;
              end else if (cur_addr_q == end_addr_q) begin
                state_q   <= StDrain;
                adpcm_din <= 4'd0;
              end else if (have_next) begin
                cur_byte_q   <= avail_byte;
                cur_addr_q   <= cur_addr_q + AW'(1);
                adpcm_din    <= avail_byte[7:4];
                half_q       <= 1'b0;
                next_valid_q <= 1'b0;
              end else begin
                // Stall: feed silence and keep waiting on the outstanding fetch.
                underrun  <= 1'b1;
                adpcm_din <= 4'd0;
              end
            end
          end
          StDrain: begin
            if (sample_cen) begin
              state_q   <= StIdle;
              done      <= 1'b1;
              adpcm_rst <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
